ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline.
- Consumes the ID/EX register outputs (E-suffixed signals) and computes ALU results, branch/jump target and PCSrc.
- Contains an iterative 32-cycle shift-add multiplier for MUL.
- Ends in the EX/MEM pipeline register (M-suffixed outputs).
- Asserts StallE to the hazard unit while a MUL is in progress.

---
 rtl/ex_stage.sv | 173 +++++++++++++++++
 tb/tb_ex_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32 pipeline.
//
// It takes the ID/EX register outputs (E suffix) and does the following:
//   - computes the ALU result, the branch/jump target and PCSrcE;
//   - runs MUL through an iterative 32-step shift-add multiplier;
//   - ends in the EX/MEM pipeline register (M suffix).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, MulE, ResultSrcE,
//   ALUControlE, RdE    control and destination register from ID/EX
//   RD1E, RD2E, PCE, ImmExtE, PCPlus4E
//                       operands, PC, immediate and PC+4
//   PCSrcE, PCTargetE   fetch redirect and target (combinational)
//   StallE              high while a MUL occupies EX (combinational)
//   RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM, WriteDataM, PCPlus4M
//                       EX/MEM register outputs
//
// Optional build macro EX_FORWARD_EN:
//   - adds the ForwardAE, ForwardBE and ResultW ports;
//   - selects forwarded operands for the ALU, WriteDataM and the multiplier.
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic              MulE,
    input  logic [1:0]        ResultSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [4:0]        RdE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [DATA_W-1:0] PCPlus4E,
`ifdef EX_FORWARD_EN
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
`endif
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              StallE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [4:0]        RdM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] PCPlus4M
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t        mul_state;
    logic [4:0]        mul_cnt;
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0] mul_mplier;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_res;
    logic              ZeroE;

    // Operands are taken as signed so that slt is a true signed compare.
    // srl uses >> (logical), not >>>.
    function automatic logic [DATA_W-1:0] alu(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            3'b000:  alu = a + b;
            3'b001:  alu = a - b;
            3'b010:  alu = a & b;
            3'b011:  alu = a | b;
            3'b100:  alu = a ^ b;
            3'b101:  alu = {{(DATA_W-1){1'b0}}, (a < b)};
            3'b110:  alu = a << b[4:0];
            default: alu = a >> b[4:0];
        endcase
    endfunction

`ifdef EX_FORWARD_EN
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
    end
`else
    assign src_a = RD1E;
    assign fwd_b = RD2E;
`endif

    assign src_b     = ALUSrcE ? ImmExtE : fwd_b;
    assign alu_res   = alu(ALUControlE, src_a, src_b);
    assign ZeroE     = (alu_res == '0);
    assign PCSrcE    = JumpE | (BranchE & ZeroE);
    assign PCTargetE = PCE + ImmExtE;
    assign StallE    = ((mul_state == IDLE) && MulE) || (mul_state == BUSY);

    // Multiplier: one shift-add step per BUSY cycle.
    // Only the low DATA_W bits of the product are kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_state  <= IDLE;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else begin
            case (mul_state)
                IDLE: begin
                    if (MulE) begin
                        mul_mcand  <= src_a;
                        mul_mplier <= fwd_b;
                        mul_acc    <= '0;
                        mul_cnt    <= '0;
                        mul_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mul_mplier[0])
                        mul_acc <= mul_acc + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 5'd1;
                    if (mul_cnt == 5'd31)
                        mul_state <= DONE;
                end
                default: mul_state <= IDLE;
            endcase
        end
    end

    // EX/MEM boundary: a stalled cycle writes a bubble.
    // In DONE, ID/EX still holds the MUL, so its controls retire along with
    // the product.
    always_ff @(posedge clk) begin
        if (reset || StallE) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= (mul_state == DONE) ? mul_acc : alu_res;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with hand-computed results.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, MulE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
`ifdef EX_FORWARD_EN
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
`endif
    logic        PCSrcE, StallE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;

    int n_chk  = 0;
    int n_fail = 0;

    ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MulE(MulE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E),
`ifdef EX_FORWARD_EN
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
`endif
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ALU vectors: op, RD1E, RD2E, ALUSrcE, ImmExtE, expected ALUResultM
    localparam int NV = 10;
    localparam logic [2:0]  V_OP  [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    localparam logic [31:0] V_A   [NV] = '{32'hFFFF_FFFF, 32'd5, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0,
                                           32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'd10};
    localparam logic [31:0] V_B   [NV] = '{32'd1, 32'd7, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00,
                                           32'd1, 32'hFFFF_FFFF, 32'd0, 32'd31, 32'd100};
    localparam logic        V_SRC [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] V_IMM [NV] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                           32'h0000_0021, 32'd0, 32'hFFFF_FFFF};
    localparam logic [31:0] V_EXP [NV] = '{32'd0, 32'hFFFF_FFFE, 32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0,
                                           32'd1, 32'd0, 32'd2, 32'd1, 32'd9};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one MUL (rd=5) and checks 33 stall/bubble cycles followed by
    // the product at edge 34.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int stalls  = 0;
        int bubbles = 0;
        RD1E = a; RD2E = b; MulE = 1'b1; RegWriteE = 1'b1; RdE = 5'd5;
        ALUControlE = 3'b000; ALUSrcE = 1'b0;
        #1;
        for (int i = 0; i < 33; i++) begin
            if (StallE) stalls++;
            tick();
            if (!RegWriteM && ALUResultM == 32'd0) bubbles++;
        end
        chk({tag, " stall cycles"}, stalls, 33);
        chk({tag, " bubbles"}, bubbles, 33);
        chk({tag, " stall low in DONE"}, StallE, 1'b0);
        tick();
        chk({tag, " product"}, ALUResultM, exp);
        chk({tag, " RegWriteM"}, RegWriteM, 1'b1);
        chk({tag, " RdM"}, RdM, 5'd5);
    endtask

    initial begin
        int n;
        // Non-zero inputs while in reset: the M outputs must still clear.
        reset = 1'b1;
        RegWriteE = 1'b1; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
        ALUSrcE = 1'b0; MulE = 1'b0; ResultSrcE = 2'b00; ALUControlE = 3'b000;
        RdE = 5'd3; RD1E = 32'd5; RD2E = 32'd7; PCE = 32'h0;
        ImmExtE = 32'h0; PCPlus4E = 32'd4;
`ifdef EX_FORWARD_EN
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
`endif
        tick();
        tick();
        chk("reset ALUResultM", ALUResultM, 32'd0);
        chk("reset RegWriteM", RegWriteM, 1'b0);
        chk("reset RdM", RdM, 5'd0);
        chk("reset PCPlus4M", PCPlus4M, 32'd0);
        chk("reset WriteDataM", WriteDataM, 32'd0);
        reset = 1'b0;
        #1;
        chk("add StallE", StallE, 1'b0);
        tick();
        chk("add ALUResultM", ALUResultM, 32'd12);
        chk("add RdM", RdM, 5'd3);
        chk("add RegWriteM", RegWriteM, 1'b1);
        chk("add WriteDataM", WriteDataM, 32'd7);
        chk("add PCPlus4M", PCPlus4M, 32'd4);

        // ALU operations
        for (int i = 0; i < NV; i++) begin
            ALUControlE = V_OP[i]; RD1E = V_A[i]; RD2E = V_B[i];
            ALUSrcE = V_SRC[i]; ImmExtE = V_IMM[i];
            tick();
            chk($sformatf("alu vec %0d", i), ALUResultM, V_EXP[i]);
        end

        // beq taken and not taken, then jump
        RegWriteE = 1'b0; ALUSrcE = 1'b0; BranchE = 1'b1; ALUControlE = 3'b001;
        RD1E = 32'd9; RD2E = 32'd9; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
        #1;
        chk("beq taken PCSrcE", PCSrcE, 1'b1);
        chk("beq PCTargetE", PCTargetE, 32'h0000_00F8);
        RD2E = 32'd8;
        #1;
        chk("beq not taken PCSrcE", PCSrcE, 1'b0);
        BranchE = 1'b0; JumpE = 1'b1;
        #1;
        chk("jump PCSrcE", PCSrcE, 1'b1);
        JumpE = 1'b0; ImmExtE = 32'd0;
        tick();

        // MUL, then two MULs back to back (the second issues in the IDLE
        // cycle right after DONE)
        run_mul("mul -1*3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        run_mul("mul 6*7", 32'd6, 32'd7, 32'd42);
        run_mul("mul 2^16*2^16", 32'h0001_0000, 32'h0001_0000, 32'd0);
        MulE = 1'b0;
        tick();

        // Reset during BUSY cycle 10, then the restarted MUL must finish
        // 34 edges after reset is released.
        RD1E = 32'd6; RD2E = 32'd7; MulE = 1'b1; RegWriteE = 1'b1; RdE = 5'd5;
        ALUControlE = 3'b000;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid reset ALUResultM", ALUResultM, 32'd0);
        chk("mid reset RegWriteM", RegWriteM, 1'b0);
        chk("mid reset RdM", RdM, 5'd0);
        chk("mid reset StallE", StallE, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (RegWriteM) break;
        end
        chk("restart latency", n, 34);
        chk("restart product", ALUResultM, 32'd42);
        MulE = 1'b0;
        tick();

`ifdef EX_FORWARD_EN
        // Produce ALUResultM=20, then forward it into a SUB.
        ALUControlE = 3'b000; RD1E = 32'd20; RD2E = 32'd0; ALUSrcE = 1'b0;
        tick();
        chk("fwd setup", ALUResultM, 32'd20);
        ForwardAE = 2'b10; RD1E = 32'd999; RD2E = 32'd1; ALUControlE = 3'b001;
        tick();
        chk("fwd A from M", ALUResultM, 32'd19);
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'd4;
        RD1E = 32'd1; RD2E = 32'd77; ALUControlE = 3'b110;
        tick();
        chk("fwd B from W", ALUResultM, 32'd16);
        chk("fwd WriteDataM", WriteDataM, 32'd4);
        ForwardBE = 2'b00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
